// File: rtl/decoder_pkg.sv
// Shared types and width helpers for the multi-address accumulating decoder.
package decoder_pkg;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    // Width needed to index n distinct values; never narrower than one bit.
    function automatic int wbits(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/multi_addr_accum_decoder_if.sv
// Beat input and frame-result output bundle; DECODER_OOR_FLAG_EN adds out_oor.
interface multi_addr_accum_decoder_if
    import decoder_pkg::*;
#(
    parameter int SIZE   = 8,
    parameter int K      = 4,
    parameter int BIT    = wbits(SIZE),
    parameter int CNT_W  = wbits(SIZE + 1),
    parameter int BEAT_W = 4
);
    logic                in_valid;
    logic                in_ready;
    logic [K*BIT-1:0]    in_addr;
    logic [K-1:0]        in_en;
    logic                in_last;
    logic                out_valid;
    logic                out_ready;
    logic [SIZE-1:0]     out_mask;
    logic [CNT_W-1:0]    out_count;
    logic                out_dup;
    logic [BEAT_W-1:0]   out_beats;
`ifdef DECODER_OOR_FLAG_EN
    logic                out_oor;
`endif

    modport master (
        output in_valid, in_addr, in_en, in_last, out_ready,
        input  in_ready, out_valid, out_mask, out_count, out_dup, out_beats
`ifdef DECODER_OOR_FLAG_EN
        , input out_oor
`endif
    );

    modport slave (
        input  in_valid, in_addr, in_en, in_last, out_ready,
        output in_ready, out_valid, out_mask, out_count, out_dup, out_beats
`ifdef DECODER_OOR_FLAG_EN
        , output out_oor
`endif
    );
endinterface

// File: rtl/multi_addr_accum_decoder_mask_popcount.sv
// Combinational population count of a SIZE-bit mask.
module mask_popcount #(
    parameter int SIZE  = 8,
    parameter int CNT_W = 4
) (
    input  logic [SIZE-1:0]  mask,
    output logic [CNT_W-1:0] count
);
    always_comb begin
        count = '0;
        for (int i = 0; i < SIZE; i++)
            count = count + CNT_W'(mask[i]);
    end
endmodule

// File: rtl/multi_addr_accum_decoder.sv
// Accumulates K address slots per beat into one multi-hot mask per frame.
// Optional out-of-range flag enabled by defining DECODER_OOR_FLAG_EN.
module multi_addr_accum_decoder
    import decoder_pkg::*;
#(
    parameter int SIZE   = 8,
    parameter int K      = 4,
    parameter int BIT    = wbits(SIZE),
    parameter int CNT_W  = wbits(SIZE + 1),
    parameter int BEAT_W = 4
) (
    input  logic clk,
    input  logic rst,
    multi_addr_accum_decoder_if.slave bus
);
    state_t            state, state_nxt;
    logic [SIZE-1:0]   acc, acc_nxt;
    logic              dup_acc, dup_nxt;
    logic [BEAT_W-1:0] beats, beats_nxt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              accept;

    logic [SIZE-1:0]   mask_q;
    logic [CNT_W-1:0]  count_q;
    logic              dup_q;
    logic [BEAT_W-1:0] beats_q;

    // prior[g] = bits set by valid slots below g in this beat
    logic [K:0][SIZE-1:0] prior;
    logic [K-1:0][SIZE-1:0] slot_oh;
    logic [K-1:0] slot_dup;

`ifdef DECODER_OOR_FLAG_EN
    logic [K-1:0] slot_oor;
    logic         oor_acc, oor_nxt, oor_q;
`endif

    assign prior[0] = '0;

    for (genvar g = 0; g < K; g++) begin : g_slot
        logic [BIT-1:0] a;
        logic           in_rng;
        assign a             = bus.in_addr[BIT*g +: BIT];
        assign in_rng        = int'(a) < SIZE;
        assign slot_oh[g]    = (bus.in_en[g] && in_rng) ? (SIZE'(1) << a) : '0;
        assign prior[g+1]    = prior[g] | slot_oh[g];
        assign slot_dup[g]   = |(slot_oh[g] & (acc | prior[g]));
`ifdef DECODER_OOR_FLAG_EN
        assign slot_oor[g]   = bus.in_en[g] && !in_rng;
`endif
    end

    assign accept    = bus.in_valid && bus.in_ready;
    assign acc_nxt   = acc | prior[K];
    assign dup_nxt   = dup_acc | (|slot_dup);
    assign beats_nxt = (&beats) ? beats : beats + BEAT_W'(1);
`ifdef DECODER_OOR_FLAG_EN
    assign oor_nxt   = oor_acc | (|slot_oor);
`endif

    mask_popcount #(.SIZE(SIZE), .CNT_W(CNT_W)) u_pop (
        .mask  (acc_nxt),
        .count (cnt_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_ACCUM;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_ACCUM: if (accept && bus.in_last) state_nxt = ST_HOLD;
            ST_HOLD:  if (bus.out_ready)         state_nxt = ST_ACCUM;
            default:                             state_nxt = ST_ACCUM;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == ST_ACCUM) && !rst;
        bus.out_valid = (state == ST_HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            dup_acc <= 1'b0;
            beats   <= '0;
            mask_q  <= '0;
            count_q <= '0;
            dup_q   <= 1'b0;
            beats_q <= '0;
`ifdef DECODER_OOR_FLAG_EN
            oor_acc <= 1'b0;
            oor_q   <= 1'b0;
`endif
        end else if (accept) begin
            if (bus.in_last) begin
                // Close the frame: publish final values, restart accumulation.
                mask_q  <= acc_nxt;
                count_q <= cnt_nxt;
                dup_q   <= dup_nxt;
                beats_q <= beats_nxt;
                acc     <= '0;
                dup_acc <= 1'b0;
                beats   <= '0;
`ifdef DECODER_OOR_FLAG_EN
                oor_q   <= oor_nxt;
                oor_acc <= 1'b0;
`endif
            end else begin
                acc     <= acc_nxt;
                dup_acc <= dup_nxt;
                beats   <= beats_nxt;
`ifdef DECODER_OOR_FLAG_EN
                oor_acc <= oor_nxt;
`endif
            end
        end
    end

    assign bus.out_mask  = mask_q;
    assign bus.out_count = count_q;
    assign bus.out_dup   = dup_q;
    assign bus.out_beats = beats_q;
`ifdef DECODER_OOR_FLAG_EN
    assign bus.out_oor   = oor_q;
`endif
endmodule

// File: doc/multi_addr_accum_decoder.md
Name: multi_addr_accum_decoder

Overview:
- Sequential successor to the combinational K-way address decoder.
- Accumulates K address slots per beat, over multiple beats, into one SIZE-bit multi-hot mask per frame.
- Flags duplicate addresses, counts set bits and beats, and delivers the result through a valid/ready output handshake.
- Sits between the address generator and the bank/line select logic.

Parameters:
- SIZE, 8, number of decoded output lines.
- K, 4, address slots per input beat.
- BIT, $clog2(SIZE), width of one address slot.
- CNT_W, $clog2(SIZE+1), width of the popcount output.
- BEAT_W, 4, width of the beat counter (saturating).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  beat offered.
- in_ready  output  1  block accepts beat.
- in_addr  input  K*BIT  slot g at bits [BIT*g +: BIT].
- in_en  input  K  per-slot enable; a disabled slot contributes nothing.
- in_last  input  1  accepted beat closes the frame.
- out_valid  output  1  frame result held.
- out_ready  input  1  consumer takes the result.
- out_mask  output  SIZE  OR of all decoded enabled in-range slots in the frame.
- out_count  output  CNT_W  popcount of out_mask.
- out_dup  output  1  some enabled in-range address hit an already-set bit in the frame.
- out_beats  output  BEAT_W  beats accepted in the frame, saturating at 2^BEAT_W-1.
- out_oor  output  1  only when DECODER_OOR_FLAG_EN is defined; see Optional Feature.

Behaviour:
- FSM has two states: ACCUM and HOLD.
  - in_ready = (state==ACCUM) && !rst.
  - out_valid = (state==HOLD).
- Reset, synchronous, while rst=1 at an edge:
  - state goes to ACCUM.
  - Accumulator mask, dup flag and beat counter go to 0.
  - out_mask, out_count, out_dup, out_beats and out_oor go to 0.
  - A reset mid-frame discards the partial frame.
  - A reset in HOLD drops the pending result.
- A beat is accepted when in_valid && in_ready.
- Slot g is valid when in_en[g]=1 and in_addr slot < SIZE. Out-of-range slots never set mask bits.
- Per accepted beat:
  - beat_mask = OR of decoded valid slots.
  - acc_next = acc | beat_mask.
  - dup is set if any valid slot's bit is already in acc, or equals a lower-index valid slot in the same beat.
  - The beat counter increments and saturates.
- Accepted beat with in_last=0: state stays ACCUM and the accumulators update.
- Accepted beat with in_last=1, same edge:
  - Final values (including this beat) are registered into the out_* registers.
  - out_count is the popcount of the final mask.
  - Accumulators clear to 0 and state goes to HOLD.
  - Latency: last accepted at edge N gives out_valid=1 from edge N to the edge where it is taken.
- HOLD:
  - out_* are stable and in_valid is ignored.
  - On out_ready=1 at an edge, state goes to ACCUM. out_valid falls and in_ready rises after that edge.
  - There is no bypass: one bubble cycle per frame.
- A frame may contain zero enabled slots, giving mask 0, count 0, dup 0.
- in_last on the first beat gives a single-beat frame.
- Duplicate slots are harmless to the mask: the bit is set once and dup is flagged.

Optional Feature:
- DECODER_OOR_FLAG_EN defined:
  - out_oor port exists.
  - Any enabled slot with addr >= SIZE in the frame sets a sticky frame flag.
  - The flag is registered with the other outputs at last, cleared at frame start and on reset.
- DECODER_OOR_FLAG_EN undefined:
  - Port and logic are absent.
  - Out-of-range enabled slots are silently ignored.
- The flag is only reachable when SIZE is not a power of two.

Decomposition:
- decoder_pkg (shared include) holds:
  - State encodings ST_ACCUM=1'b0 and ST_HOLD=1'b1.
  - A clog2-based width helper for CNT_W/BIT.
- One sub-module, mask_popcount (parameter SIZE, CNT_W), is purely combinational: SIZE-bit mask in, count out. It is reused for out_count.
- Slot decode and duplicate detection stay in a generate loop in the top module.

Test Plan:
- SIZE=8, K=4; one beat with addr {0,3,5,7}, en=1111, last=1 -> next cycle out_valid=1, mask=8'b1010_1001, count=4, dup=0, beats=1.
- Two beats:
  - Beat 1: slots {1,2}, en=0011, last=0.
  - Beat 2: slots {2,6}, en=0011, last=1.
  - -> mask=8'b0100_0110, count=3, dup=1, beats=2.
- Result held with out_ready=0 for 5 cycles while in_valid=1 -> out_* stable, in_ready=0, no beat counted. Then out_ready=1 -> next cycle out_valid=0, in_ready=1.
- Single beat en=0000, last=1 -> mask=0, count=0, dup=0, beats=1.
- Reset mid-frame:
  - Accept {3}, last=0, then rst=1 for one cycle.
  - Then frame {4}, last=1.
  - -> mask=8'b0001_0000, beats=1, dup=0.
- DECODER_OOR_FLAG_EN, SIZE=6, BIT=3; one beat slots {7,2}, en=0011, last=1 -> mask=6'b000100, count=1, out_oor=1. Next frame {2}, last=1 -> out_oor=0.
